// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default geometry for the data-side
// write-through cache (one 32-bit word per line).
package dmem_pkg;
    localparam int INDEX_BITS = 8;
    localparam int TAG_BITS   = 30 - INDEX_BITS;
    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: data/tag/valid storage, one async read port, one sync
// write port, valid bits cleared synchronously by rst.
module dmem_line_array #(
    parameter int INDEX_BITS = dmem_pkg::INDEX_BITS,
    parameter int TAG_BITS   = dmem_pkg::TAG_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [31:0]           wr_data_i
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [31:0]         data_q [LINES];
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [LINES-1:0]    valid_q;
    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else if (wr_en_i)
            valid_q[wr_idx_i] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i] <= wr_data_i;
            tag_q[wr_idx_i]  <= wr_tag_i;
        end
    end
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: direct-mapped write-through data cache with zero-stall hits.
// DCACHE_WRITE_ALLOCATE_EN: when defined, store misses install the stored word.
module data_mem_responder import dmem_pkg::*; #(
    parameter int INDEX_BITS = dmem_pkg::INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] data_addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int TAG_W = 30 - INDEX_BITS;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif
    dmem_state_t state_q, state_d;
    logic [31:0]           word_addr;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag, line_tag;
    logic                  line_valid, hit, wr_en;
    logic [31:0]           line_data, wr_data;
    assign word_addr = data_addr & 32'hFFFF_FFFC;
    assign idx       = word_addr[INDEX_BITS+1:2];
    assign tag       = word_addr[31:INDEX_BITS+2];
    assign hit       = line_valid && line_tag == tag;
    dmem_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_W)) u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (wr_data)
    );
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = we ? WRITE : (re && !hit) ? FILL : IDLE;
            FILL:    state_d = mem_ack ? RESP : FILL;
            WRITE:   state_d = mem_ack ? IDLE : WRITE;
            default: state_d = IDLE;
        endcase
    end
    // The requester holds its address through FILL/RESP, so RESP reads the freshly filled line.
    always_comb begin
        stall     = (state_q == IDLE) ? (we || (re && !hit))
                                      : (state_q == FILL) || (state_q == WRITE && !mem_ack);
        mem_req   = state_q == FILL || state_q == WRITE;
        mem_we    = state_q == WRITE;
        mem_addr  = mem_req ? word_addr : '0;
        mem_wdata = mem_we ? din : '0;
        dout      = ((state_q == IDLE && re && !we && hit) || state_q == RESP) ? line_data : '0;
        wr_en     = !rst && ((state_q == IDLE && we && (hit || ALLOC)) || (state_q == FILL && mem_ack));
        wr_data   = (state_q == FILL) ? mem_rdata : din;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector table, reset-abort sequence and random
// traffic checked against a tag/valid map plus a word-addressed backing store.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst, we, re, mem_ack;
    logic [31:0] data_addr, din, mem_rdata;
    logic [31:0] dout, mem_addr, mem_wdata;
    logic        stall, mem_req, mem_we;
    int nvec = 0;
    int nerr = 0;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif
    logic [31:0] bmem [logic [29:0]];
    bit          mv [256];
    logic [21:0] mt [256];

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        st;
        logic [31:0] dv;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .re        (re),
        .data_addr (data_addr),
        .din       (din),
        .dout      (dout),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] backing(input logic [29:0] wa);
        return bmem.exists(wa) ? bmem[wa] : {wa[15:0], ~wa[15:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One request from the first cycle it is presented until the pipeline is released.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input bit stray, output logic st0, output logic [31:0] rd);
        logic [29:0] wa;
        logic [7:0]  ix;
        bit          hit;
        wa  = a[31:2];
        ix  = a[9:2];
        hit = mv[ix] && mt[ix] == a[31:10];
        we = w; re = r; data_addr = a; din = d;
        mem_ack = stray; mem_rdata = 32'hBADC0DE5;
        #1;
        st0 = stall;
        rd  = dout;
        if (w) begin
            chk("st_stall0", 32'(stall), 32'd1);
            chk("st_req0", 32'(mem_req), 32'd0);
            tick;
            mem_ack = 1'b0;
            for (int c = 0; c <= lat; c++) begin
                mem_ack = (c == lat);
                #1;
                chk("wr_req", 32'(mem_req), 32'd1);
                chk("wr_we", 32'(mem_we), 32'd1);
                chk("wr_addr", mem_addr, {a[31:2], 2'b00});
                chk("wr_wdata", mem_wdata, d);
                chk("wr_stall", 32'(stall), 32'(c != lat));
                tick;
                mem_ack = 1'b0;
            end
            bmem[wa] = d;
            if (hit || ALLOC) begin
                mv[ix] = 1'b1;
                mt[ix] = a[31:10];
            end
        end else if (r && hit) begin
            chk("hit_stall", 32'(stall), 32'd0);
            chk("hit_dout", dout, backing(wa));
            chk("hit_req", 32'(mem_req), 32'd0);
            tick;
            mem_ack = 1'b0;
        end else if (r) begin
            chk("miss_stall0", 32'(stall), 32'd1);
            chk("miss_req0", 32'(mem_req), 32'd0);
            tick;
            mem_ack = 1'b0;
            for (int c = 0; c <= lat; c++) begin
                mem_rdata = backing(wa);
                mem_ack = (c == lat);
                #1;
                chk("fill_req", 32'(mem_req), 32'd1);
                chk("fill_we", 32'(mem_we), 32'd0);
                chk("fill_addr", mem_addr, {a[31:2], 2'b00});
                chk("fill_stall", 32'(stall), 32'd1);
                chk("fill_dout", dout, 32'd0);
                tick;
                mem_ack = 1'b0;
            end
            #1;
            chk("resp_stall", 32'(stall), 32'd0);
            chk("resp_dout", dout, backing(wa));
            chk("resp_req", 32'(mem_req), 32'd0);
            rd = dout;
            tick;
            mv[ix] = 1'b1;
            mt[ix] = a[31:10];
        end else begin
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_dout", dout, 32'd0);
            chk("idle_req", 32'(mem_req), 32'd0);
            tick;
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        logic        st0;
        logic [31:0] rd;
        rst = 1'b1; we = 1'b0; re = 1'b0; mem_ack = 1'b0;
        data_addr = '0; din = '0; mem_rdata = '0;
        bmem[30'h40]  = 32'hDEADBEEF;
        bmem[30'h140] = 32'h55550500;
        tick;
        tick;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_dout", dout, 32'd0);
        rst = 1'b0;
        tick;

        tbl[0] = '{1'b0, 1'b1, 32'h100, 32'h0,        3, 1'b1,  32'hDEADBEEF};
        tbl[1] = '{1'b0, 1'b1, 32'h100, 32'h0,        0, 1'b0,  32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'h100, 32'h12345678, 2, 1'b1,  32'h0};
        tbl[3] = '{1'b0, 1'b1, 32'h102, 32'h0,        0, 1'b0,  32'h12345678};
        tbl[4] = '{1'b0, 1'b1, 32'h500, 32'h0,        1, 1'b1,  32'h55550500};
        tbl[5] = '{1'b0, 1'b1, 32'h100, 32'h0,        2, 1'b1,  32'h12345678};
        tbl[6] = '{1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 1, 1'b1,  32'h0};
        tbl[7] = '{1'b0, 1'b1, 32'h200, 32'h0,        1, !ALLOC, 32'hCAFEF00D};
        tbl[8] = '{1'b0, 1'b0, 32'h200, 32'h0,        0, 1'b0,  32'h0};
        for (int i = 0; i < 9; i++) begin
            access(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].lat, 1'b0, st0, rd);
            chk($sformatf("tbl%0d_stall", i), 32'(st0), 32'(tbl[i].st));
            if (!tbl[i].w)
                chk($sformatf("tbl%0d_dout", i), rd, tbl[i].dv);
        end

        // Reset while a fill is outstanding, then a late ack that must be ignored.
        we = 1'b0; re = 1'b1; data_addr = 32'h300;
        #1;
        chk("abort_stall0", 32'(stall), 32'd1);
        tick;
        chk("abort_fill_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0; re = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick;
        mem_ack = 1'b0;
        #1;
        chk("stray_req", 32'(mem_req), 32'd0);
        chk("stray_stall", 32'(stall), 32'd0);
        tick;
        foreach (mv[i]) mv[i] = 1'b0;
        access(1'b0, 1'b1, 32'h100, 32'h0, 1, 1'b0, st0, rd);
        chk("post_rst_100_miss", 32'(st0), 32'd1);
        chk("post_rst_100_data", rd, 32'h12345678);
        access(1'b0, 1'b1, 32'h300, 32'h0, 0, 1'b0, st0, rd);
        chk("post_rst_300_miss", 32'(st0), 32'd1);

        for (int n = 0; n < 300; n++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 9));
            a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            access(op >= 6, (op >= 2 && op <= 5) || op == 9, a, $urandom,
                   int'($urandom_range(0, 4)), op < 2 && $urandom_range(0, 2) == 0, st0, rd);
        end
        we = 1'b0; re = 1'b0;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter: INDEX_BITS, 8, log2 of line count (one 32-bit word per line).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: we  input  1  store request from memory-access stage.
REQ-005 SHALL have port: re  input  1  load request from memory-access stage.
REQ-006 SHALL have port: data_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port: din  input  32  store data.
REQ-008 SHALL have port: dout  output  32  load data, valid when re=1 and stall=0.
REQ-009 SHALL have port: stall  output  1  freeze pipeline; requester holds we/re/data_addr/din stable while 1.
REQ-010 SHALL have port: mem_req  output  1  backing-store request.
REQ-011 SHALL have port: mem_we  output  1  backing-store write (1) or read (0).
REQ-012 SHALL have port: mem_addr  output  32  backing-store word address, bits [1:0]=0.
REQ-013 SHALL have port: mem_wdata  output  32  backing-store write data.
REQ-014 SHALL have port: mem_ack  input  1  one-cycle completion pulse from backing store.
REQ-015 SHALL have port: mem_rdata  input  32  read data, valid with mem_ack.

Function
REQ-016 SHALL be a direct-mapped, write-through cache: index = data_addr[INDEX_BITS+1:2], tag = data_addr[31:INDEX_BITS+2], one valid bit per line.
REQ-017 SHALL implement FSM states IDLE, FILL, WRITE, RESP.
REQ-018 SHALL, in IDLE, on re=1 with hit, drive dout from the line combinationally, stall=0, and remain in IDLE (zero-stall hit).
REQ-019 SHALL, in IDLE, on re=1 with miss, assert stall combinationally in the same cycle and go to FILL.
REQ-020 SHALL, in FILL, hold mem_req=1, mem_we=0, mem_addr={data_addr[31:2],2'b00}; on mem_ack, write mem_rdata, tag and valid=1 to the line and go to RESP.
REQ-021 SHALL, in RESP, drive dout with the filled word, stall=0, and go to IDLE (read miss = 1 + ack-wait + 1 cycles).
REQ-022 SHALL, in IDLE, on we=1, assert stall and go to WRITE; a hit line is updated with din on entry.
REQ-023 SHALL, in WRITE, hold mem_req=1, mem_we=1, mem_wdata=din; on mem_ack, deassert stall in that same cycle and go to IDLE.
REQ-024 SHALL treat we=1 and re=1 together as a store only; dout is then undefined.
REQ-025 SHALL keep mem_req asserted continuously until mem_ack; a mem_ack outside FILL/WRITE is ignored.
REQ-026 SHALL keep stall=1 in FILL and WRITE and stall=0 in RESP and in idle cycles with no request.
REQ-027 SHALL drive dout=0 when not presenting load data.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE, clear every valid bit within that edge, and drive stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dout=0.
REQ-029 SHALL, on reset during FILL/WRITE, abandon the transaction without writing the line; a later stray mem_ack is ignored.

Configuration
REQ-030 SHALL support macro DCACHE_WRITE_ALLOCATE_EN: defined -> a store miss installs din, tag and valid=1 in the line; undefined -> a store miss leaves the line unchanged. Store hits are updated in both cases.

Structure
REQ-031 SHALL place state enum dmem_state_t, the default INDEX_BITS and the derived TAG_BITS in shared package dmem_pkg.
REQ-032 SHALL isolate the data, tag and valid storage in sub-module dmem_line_array (1 async read port, 1 sync write port, synchronous valid clear).

Verification
REQ-033 SHALL cover: after reset, re=1 at 0x0000_0100 -> stall=1, mem_req=1 with mem_addr=0x100; mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> next cycle dout=0xDEADBEEF, stall=0.
REQ-034 SHALL cover: re=1 at 0x100 repeated -> hit, stall=0, dout=0xDEADBEEF in the same cycle, mem_req stays 0.
REQ-035 SHALL cover: we=1 at 0x100, din=0x12345678 -> mem_req=1, mem_we=1, mem_wdata=0x12345678 until ack; then a load of 0x100 hits with 0x12345678.
REQ-036 SHALL cover: aliasing addresses 0x100 and 0x500 (INDEX_BITS=8) -> load of 0x500 misses and evicts; a reload of 0x100 misses again.
REQ-037 SHALL cover: rst=1 during FILL -> mem_req=0 the next cycle; a later mem_ack is ignored; a reload of 0x100 misses.
REQ-038 SHALL cover: store miss at 0x200, then load 0x200 -> hit with DCACHE_WRITE_ALLOCATE_EN defined, miss without it.
